bias_relu_layer1_10: RTL

BIAS_RELU_LAYER1_10 -- requirements
Module: bias_relu_layer1_10

---
 rtl/bias_relu_layer1_10_pkg.sv | 22 ++
 rtl/bias_relu_layer1_10_relu_sat.sv | 40 ++++
 rtl/bias_relu_layer1_10.sv | 99 +++++++++
 3 files changed

// File: rtl/bias_relu_layer1_10_pkg.sv
// Shared definitions for the layer-1 slice-10 bias + ReLU stage: FSM encoding,
// default widths/shifts and the packed-bus width helper.
package bias_relu_layer1_10_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_PROC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int DEF_OUT_SIZE   = 8;
  localparam int DEF_W          = 8;
  localparam int DEF_ACC_W      = 20;
  localparam int DEF_BIAS_SHIFT = 4;
  localparam int DEF_OUT_SHIFT  = 4;

  function automatic int packed_width(input int n, input int w);
    return n * w;
  endfunction

endpackage

// File: rtl/bias_relu_layer1_10_relu_sat.sv
// Combinational per-neuron datapath: bias alignment and add, ReLU, rescale and
// saturation to the signed activation range.
module bias_relu_layer1_10_relu_sat
  import bias_relu_layer1_10_pkg::*;
#(
  parameter int W          = DEF_W,
  parameter int ACC_W      = DEF_ACC_W,
  parameter int BIAS_SHIFT = DEF_BIAS_SHIFT,
  parameter int OUT_SHIFT  = DEF_OUT_SHIFT
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [W-1:0]     bias,
  output logic [W-1:0]     act
);

  // Two guard bits keep the sum of a shifted bias and a full-range accumulator exact.
  localparam int SUM_W = ACC_W + 2;
  localparam logic signed [SUM_W-1:0] ACT_MAX = SUM_W'((1 << (W - 1)) - 1);

  logic signed [SUM_W-1:0] acc_ext;
  logic signed [SUM_W-1:0] bias_ext;
  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] q;

  always_comb begin
    acc_ext  = SUM_W'($signed(acc));
    bias_ext = SUM_W'($signed(bias)) <<< BIAS_SHIFT;
    sum      = acc_ext + bias_ext;
    q        = sum >>> OUT_SHIFT;
    act      = '0;
    if (sum[SUM_W-1]) begin
      act = '0;
    end else if (q > ACT_MAX) begin
      act = ACT_MAX[W-1:0];
    end else begin
      act = q[W-1:0];
    end
  end

endmodule

// File: rtl/bias_relu_layer1_10.sv
// Bias + ReLU stage for layer 1, slice 10: captures biases and MAC sums once,
// then produces one activation per cycle through a shared relu_sat datapath.
module bias_relu_layer1_10
  import bias_relu_layer1_10_pkg::*;
#(
  parameter int OUT_SIZE   = DEF_OUT_SIZE,
  parameter int W          = DEF_W,
  parameter int ACC_W      = DEF_ACC_W,
  parameter int BIAS_SHIFT = DEF_BIAS_SHIFT,
  parameter int OUT_SHIFT  = DEF_OUT_SHIFT
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      start,
  input  logic [packed_width(OUT_SIZE, W)-1:0]      bias_in,
  input  logic                                      bias_done,
  input  logic [packed_width(OUT_SIZE, ACC_W)-1:0]  acc_in,
  input  logic                                      acc_valid,
  output logic [packed_width(OUT_SIZE, W)-1:0]      act_out,
  output logic                                      busy,
  output logic                                      done
);

  localparam int IDX_W = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_SIZE - 1);

  state_t                                    state;
  logic [IDX_W-1:0]                          idx;
  logic [packed_width(OUT_SIZE, W)-1:0]      bias_q;
  logic [packed_width(OUT_SIZE, ACC_W)-1:0]  acc_q;
  logic [W-1:0]                              bias_cur;
  logic [ACC_W-1:0]                          acc_cur;
  logic [W-1:0]                              act_cur;

  assign bias_cur = bias_q[idx*W +: W];
  assign acc_cur  = acc_q[idx*ACC_W +: ACC_W];

  bias_relu_layer1_10_relu_sat #(
    .W          (W),
    .ACC_W      (ACC_W),
    .BIAS_SHIFT (BIAS_SHIFT),
    .OUT_SHIFT  (OUT_SHIFT)
  ) relu_sat (
    .acc  (acc_cur),
    .bias (bias_cur),
    .act  (act_cur)
  );

  // done is raised on the first full DONE cycle so it trails the last write by one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      idx     <= '0;
      bias_q  <= '0;
      acc_q   <= '0;
      act_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_WAIT;
            busy  <= 1'b1;
          end
        end
        S_WAIT: begin
          if (bias_done && acc_valid) begin
            bias_q <= bias_in;
            acc_q  <= acc_in;
            idx    <= '0;
            state  <= S_PROC;
          end
        end
        S_PROC: begin
          act_out[idx*W +: W] <= act_cur;
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            state <= S_DONE;
            busy  <= 1'b0;
          end
        end
        S_DONE: begin
          if (start) begin
            state <= S_WAIT;
            busy  <= 1'b1;
            done  <= 1'b0;
          end else begin
            done <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
